// File: rtl/shr_serial_driver_pkg.sv
// Shared definitions for the multi-channel SYNC/CLK/DIN serial driver: state encoding,
// shift phase constants and default parameter values.
package shr_drv_pkg;

  localparam int N_CH_DEF    = 4;
  localparam int MAX_LEN_DEF = 1024;
  localparam int LEN_W_DEF   = 11;
  localparam int DIV_W_DEF   = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SYNC  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_POST  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Each shifted bit spends one tick low (data launch) and one tick high (data held).
  localparam logic PH_L = 1'b0;
  localparam logic PH_H = 1'b1;

endpackage

// File: rtl/shr_serial_driver_if.sv
// Host <-> driver bundle for shr_serial_driver. The rpt signal exists only when REPEAT_EN is defined.
interface shr_serial_driver_if #(
  parameter int N_CH    = 4,
  parameter int MAX_LEN = 1024,
  parameter int LEN_W   = 11,
  parameter int DIV_W   = 5
);
  logic                      trig;
  logic                      clr_mode;
  logic                      clr_2_one;
  logic [N_CH*MAX_LEN-1:0]   data_reg;
  logic [LEN_W-1:0]          seq_length;
  logic [DIV_W-1:0]          div_base;
`ifdef REPEAT_EN
  logic                      rpt;
`endif
  logic                      clk;
  logic [N_CH-1:0]           dout;
  logic                      syn;
  logic                      out_en;
  logic                      done;

  modport master (
    output trig, clr_mode, clr_2_one, data_reg, seq_length, div_base,
`ifdef REPEAT_EN
    output rpt,
`endif
    input  clk, dout, syn, out_en, done
  );

  modport slave (
    input  trig, clr_mode, clr_2_one, data_reg, seq_length, div_base,
`ifdef REPEAT_EN
    input  rpt,
`endif
    output clk, dout, syn, out_en, done
  );
endinterface

// File: rtl/shr_tick_div.sv
// Tick divider: down-counter reloaded from a value latched on load; one-cycle tick every base+1 enabled cycles.
module shr_tick_div #(
  parameter int DIV_W = 5
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] base,
  output logic             tick
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] base_q, base_d;

  // Next count: load snapshots the period, otherwise count down and reload on the tick.
  always_comb begin
    cnt_d  = cnt_q;
    base_d = base_q;
    if (load) begin
      cnt_d  = base;
      base_d = base;
    end else if (en) begin
      if (cnt_q == {DIV_W{1'b0}}) begin
        cnt_d = base_q;
      end else begin
        cnt_d = cnt_q - DIV_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter and period registers.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      cnt_q  <= {DIV_W{1'b0}};
      base_q <= {DIV_W{1'b0}};
    end else begin
      cnt_q  <= cnt_d;
      base_q <= base_d;
    end
  end

  assign tick = en & ~load & (cnt_q == {DIV_W{1'b0}});
endmodule

// File: rtl/shr_serial_driver.sv
// Multi-channel serial pattern driver: one shared serial clock and active-low SYNC, N_CH DIN lines.
// Build option REPEAT_EN adds rpt for back-to-back replay of the latched frame.
import shr_drv_pkg::*;

module shr_serial_driver #(
  parameter int N_CH    = N_CH_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int DIV_W   = DIV_W_DEF
) (
  input  logic              clk_in,
  input  logic              rst_n,
  shr_serial_driver_if.slave bus
);
  localparam int              IDX_W     = $clog2(MAX_LEN);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_e                         state_q, state_d;
  logic                           ph_q, ph_d;
  logic [LEN_W-1:0]               len_q, len_d;
  logic [LEN_W-1:0]               idx_q, idx_d;
  logic                           clr_q, clr_d;
  logic                           one_q, one_d;
  logic [N_CH-1:0][MAX_LEN-1:0]   mem_q, mem_d;
  logic                           sy1_q, sy2_q, sy3_q;
  logic                           clk_q, clk_d;
  logic                           syn_q, syn_d;
  logic                           out_en_q, out_en_d;
  logic                           done_q, done_d;
  logic [N_CH-1:0]                dout_q, dout_d;
  logic                           trig_edge_s;
  logic                           tick_s;
  logic                           rpt_s;

`ifdef REPEAT_EN
  assign rpt_s = bus.rpt;
`else
  assign rpt_s = 1'b0;
`endif

  assign trig_edge_s = sy2_q & ~sy3_q;

  shr_tick_div #(.DIV_W(DIV_W)) u_div (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .load   (state_q == ST_LOAD),
    .en     ((state_q != ST_IDLE) && (state_q != ST_LOAD)),
    .base   (bus.div_base),
    .tick   (tick_s)
  );

  // Next state, frame snapshot, and the output values for the coming cycle.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    len_d   = len_q;
    idx_d   = idx_q;
    clr_d   = clr_q;
    one_d   = one_q;
    mem_d   = mem_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trig_edge_s) state_d = ST_LOAD;
        else             state_d = ST_IDLE;
      end
      ST_LOAD: begin
        len_d = (bus.seq_length > MAX_LEN_L) ? MAX_LEN_L : bus.seq_length;
        clr_d = bus.clr_mode;
        one_d = bus.clr_2_one;
        mem_d = bus.data_reg;
        if (len_d == {LEN_W{1'b0}}) state_d = ST_DONE;
        else                        state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (tick_s) begin
          state_d = ST_SHIFT;
          ph_d    = PH_L;
          idx_d   = len_q - LEN_W'(1);
        end else begin
          state_d = ST_SYNC;
        end
      end
      ST_SHIFT: begin
        if (!tick_s) begin
          state_d = ST_SHIFT;
        end else if (ph_q == PH_L) begin
          ph_d = PH_H;
        end else if (idx_q == {LEN_W{1'b0}}) begin
          state_d = ST_POST;
        end else begin
          idx_d = idx_q - LEN_W'(1);
          ph_d  = PH_L;
        end
      end
      ST_POST: begin
        // A replayed frame reports its completion on the way back into SYNC.
        if (!tick_s) begin
          state_d = ST_POST;
        end else if (rpt_s) begin
          state_d = ST_SYNC;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    syn_d    = ~((state_d == ST_SYNC) || (state_d == ST_SHIFT));
    out_en_d = (state_d == ST_LOAD) || (state_d == ST_SYNC) ||
               (state_d == ST_SHIFT) || (state_d == ST_POST);
    done_d   = done_d | (state_d == ST_DONE);
    clk_d    = (state_d == ST_SHIFT) && (ph_d == PH_H);
    dout_d   = {N_CH{1'b0}};
    // Data tracks the bit index, so it only moves when a new low phase begins.
    if (state_d == ST_SHIFT) begin
      for (int c = 0; c < N_CH; c++) begin
        dout_d[c] = clr_q ? one_q : mem_q[c][idx_d[IDX_W-1:0]];
      end
    end else begin
      dout_d = {N_CH{1'b0}};
    end
  end

  // Control state, synchroniser and registered outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ph_q     <= PH_L;
      len_q    <= {LEN_W{1'b0}};
      idx_q    <= {LEN_W{1'b0}};
      clr_q    <= 1'b0;
      one_q    <= 1'b0;
      sy1_q    <= 1'b0;
      sy2_q    <= 1'b0;
      sy3_q    <= 1'b0;
      clk_q    <= 1'b0;
      syn_q    <= 1'b1;
      out_en_q <= 1'b0;
      done_q   <= 1'b0;
      dout_q   <= {N_CH{1'b0}};
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      clr_q    <= clr_d;
      one_q    <= one_d;
      sy1_q    <= bus.trig;
      sy2_q    <= sy1_q;
      sy3_q    <= sy2_q;
      clk_q    <= clk_d;
      syn_q    <= syn_d;
      out_en_q <= out_en_d;
      done_q   <= done_d;
      dout_q   <= dout_d;
    end
  end

  // Pattern snapshot; contents are don't-care until the first LOAD.
  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

  assign bus.clk    = clk_q;
  assign bus.syn    = syn_q;
  assign bus.out_en = out_en_q;
  assign bus.done   = done_q;
  assign bus.dout   = dout_q;
endmodule

// File: tb/tb_shr_serial_driver.sv
// Self-checking bench for shr_serial_driver (N_CH=2): table vectors, random frames against a
// waveform reference model, and hand-written sequences for mid-frame and reset corner cases.
module tb_shr_serial_driver;
  import shr_drv_pkg::*;

  localparam int N_CH = 2, MAX_LEN = 1024, LEN_W = 11, DIV_W = 5;

  typedef struct packed {
    logic            clk;
    logic            syn;
    logic            oe;
    logic            done;
    logic [N_CH-1:0] dout;
  } smp_t;

  typedef struct {
    int          len;
    int          dv;
    bit          clr;
    bit          one;
    logic [31:0] w0;
    logic [31:0] w1;
    int          exp_syn;
    int          exp_frame;
  } vec_t;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  int   checks = 0;
  int   failures = 0;
  smp_t exp_q[$];
  smp_t obs_q[$];

  always #5 clk_in = ~clk_in;

  shr_serial_driver_if #(.N_CH(N_CH), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .DIV_W(DIV_W)) bus ();

  shr_serial_driver #(.N_CH(N_CH), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .DIV_W(DIV_W)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic smp_t mk(input logic c, input logic s, input logic o, input logic d,
                              input logic [N_CH-1:0] q);
    return {c, s, o, d, q};
  endfunction

  function automatic smp_t sample();
    return {bus.clk, bus.syn, bus.out_en, bus.done, bus.dout};
  endfunction

  // Expected per-cycle outputs from LOAD through DONE for one frame.
  task automatic build_model(input int len, input int dv, input bit clr, input bit one,
                             input logic [N_CH*MAX_LEN-1:0] data);
    int L;
    logic [N_CH-1:0] b;
    L = (len > MAX_LEN) ? MAX_LEN : len;
    exp_q.delete();
    exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, '0));
    if (L > 0) begin
      for (int t = 0; t <= dv; t++) exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, '0));
      for (int k = 0; k < L; k++) begin
        for (int c = 0; c < N_CH; c++) b[c] = clr ? one : data[c*MAX_LEN + (L-1-k)];
        for (int t = 0; t <= dv; t++) exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, b));
        for (int t = 0; t <= dv; t++) exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, b));
      end
      for (int t = 0; t <= dv; t++) exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, '0));
    end
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, '0));
  endtask

  task automatic run_frame(input int len, input int dv, input bit clr, input bit one,
                           input logic [31:0] w0, input logic [31:0] w1, input bit disturb,
                           output int syn_low, output int frame_cyc, output int lat,
                           output int clk_rises);
    logic [N_CH*MAX_LEN-1:0] data;
    smp_t cur;
    logic prev_clk;
    bit   seen, fin;
    int   first, busy;
    for (int i = 0; i < N_CH*MAX_LEN/32; i++) data[i*32 +: 32] = $urandom;
    data[31:0]        = w0;
    data[MAX_LEN +: 32] = w1;
    build_model(len, dv, clr, one, data);
    @(negedge clk_in);
    bus.data_reg   = data;
    bus.seq_length = LEN_W'(len);
    bus.div_base   = DIV_W'(dv);
    bus.clr_mode   = clr;
    bus.clr_2_one  = one;
    bus.trig       = 1'b1;
    obs_q.delete();
    lat = -1; syn_low = 0; clk_rises = 0; prev_clk = 1'b0; seen = 1'b0; fin = 1'b0;
    for (int cyc = 1; cyc <= 6000 && !fin; cyc++) begin
      @(negedge clk_in);
      cur = sample();
      if (disturb) begin
        if (cyc == 6) bus.trig = 1'b0;
        if (cyc == 12) bus.trig = 1'b1;
        if (cyc == 10) begin
          bus.seq_length = LEN_W'(3);
          bus.div_base   = DIV_W'(0);
          bus.clr_mode   = ~clr;
          bus.clr_2_one  = ~one;
          bus.data_reg   = ~data;
        end
      end
      if (!seen && cur.oe) begin
        seen = 1'b1;
        lat  = cyc;
      end
      if (seen) begin
        obs_q.push_back(cur);
        if (!cur.syn) syn_low++;
        if (cur.clk && !prev_clk) clk_rises++;
        prev_clk = cur.clk;
        if (cur.done) fin = 1'b1;
      end
    end
    check("frame_done_seen", int'(fin), 1);
    frame_cyc = obs_q.size();
    checks++;
    first = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (first < 0 && (i >= obs_q.size() || obs_q[i] !== exp_q[i])) first = i;
    if (first < 0 && obs_q.size() != exp_q.size()) first = exp_q.size();
    if (first >= 0) begin
      failures++;
      if (first < obs_q.size() && first < exp_q.size())
        $display("FAIL wave len=%0d div=%0d cycle=%0d actual=%h required=%h",
                 len, dv, first, obs_q[first], exp_q[first]);
      else
        $display("FAIL wave_len len=%0d div=%0d actual=%0d required=%0d",
                 len, dv, obs_q.size(), exp_q.size());
    end
    bus.trig = 1'b0;
    busy = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      if (bus.out_en) busy++;
    end
    check("no_restart", busy, 0);
  endtask

  vec_t tbl[8];
  int   s_low, f_cyc, lat, rises, L, dv, ln, dn, oe_n;

  initial begin
    tbl[0] = '{4,    0,  1'b0, 1'b0, 32'hA,  32'h6, 9,    12};
    tbl[1] = '{2,    3,  1'b0, 1'b0, 32'h2,  32'h1, 20,   26};
    tbl[2] = '{8,    1,  1'b1, 1'b1, 32'h0,  32'h0, 34,   38};
    tbl[3] = '{8,    0,  1'b1, 1'b0, 32'hFF, 32'hFF, 17,  20};
    tbl[4] = '{0,    2,  1'b0, 1'b0, 32'h5,  32'h5, 0,    2};
    tbl[5] = '{2000, 0,  1'b0, 1'b0, 32'h3C, 32'hC3, 2049, 2052};
    tbl[6] = '{1,    4,  1'b0, 1'b0, 32'h1,  32'h0, 15,   22};
    tbl[7] = '{5,    31, 1'b0, 1'b0, 32'h15, 32'h0A, 352, 386};

    bus.trig = 1'b0; bus.clr_mode = 1'b0; bus.clr_2_one = 1'b0;
    bus.data_reg = '0; bus.seq_length = '0; bus.div_base = '0;
`ifdef REPEAT_EN
    bus.rpt = 1'b0;
`endif
    repeat (3) @(negedge clk_in);
    check("rst_syn", int'(bus.syn), 1);
    check("rst_clk", int'(bus.clk), 0);
    check("rst_oe", int'(bus.out_en), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_dout", int'(bus.dout), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);

    foreach (tbl[i]) begin
      run_frame(tbl[i].len, tbl[i].dv, tbl[i].clr, tbl[i].one, tbl[i].w0, tbl[i].w1, 1'b0,
                s_low, f_cyc, lat, rises);
      check($sformatf("tbl%0d_latency", i), lat, 3);
      check($sformatf("tbl%0d_syn_low", i), s_low, tbl[i].exp_syn);
      check($sformatf("tbl%0d_frame", i), f_cyc, tbl[i].exp_frame);
      check($sformatf("tbl%0d_clk_rises", i), rises, (tbl[i].len > MAX_LEN) ? MAX_LEN : tbl[i].len);
    end

    for (int r = 0; r < 12; r++) begin
      L  = $urandom_range(0, 24);
      dv = $urandom_range(0, 3);
      run_frame(L, dv, ($urandom_range(0, 3) == 0), $urandom_range(0, 1), $urandom, $urandom, 1'b0,
                s_low, f_cyc, lat, rises);
      check("rnd_syn_low", s_low, (L == 0) ? 0 : (2*L + 1) * (dv + 1));
    end

    // Second trig edge and input changes while a frame is running.
    run_frame(8, 1, 1'b0, 1'b0, 32'hB4, 32'h5A, 1'b1, s_low, f_cyc, lat, rises);
    check("mid_syn_low", s_low, 34);
    check("mid_clk_rises", rises, 8);

    // Reset during bit 3 aborts the frame without a done pulse.
    @(negedge clk_in);
    bus.seq_length = LEN_W'(8); bus.div_base = DIV_W'(1); bus.clr_mode = 1'b0;
    bus.trig = 1'b1;
    rises = 0;
    for (int cyc = 0; cyc < 200 && rises < 3; cyc++) begin
      @(negedge clk_in);
      if (bus.clk) rises = rises + ((cyc > 0 && !obs_q[0].clk) ? 1 : 0);
      obs_q[0] = sample();
    end
    check("rst_reach_bit3", rises, 3);
    rst_n = 1'b0; bus.trig = 1'b0;
    @(negedge clk_in);
    check("midrst_syn", int'(bus.syn), 1);
    check("midrst_clk", int'(bus.clk), 0);
    check("midrst_oe", int'(bus.out_en), 0);
    check("midrst_done", int'(bus.done), 0);
    rst_n = 1'b1;
    dn = 0; oe_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      if (bus.done) dn++;
      if (bus.out_en) oe_n++;
    end
    check("midrst_no_done", dn, 0);
    check("midrst_no_oe", oe_n, 0);

`ifdef REPEAT_EN
    // Replay: three frames of len 3, rpt dropped after the second done pulse.
    @(negedge clk_in);
    bus.seq_length = LEN_W'(3); bus.div_base = DIV_W'(0); bus.rpt = 1'b1; bus.trig = 1'b1;
    dn = 0; ln = 0; oe_n = 0; s_low = 0;
    begin : rpt_run
      bit seen_oe;
      seen_oe = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
        @(negedge clk_in);
        if (bus.done) dn++;
        if (dn == 2) bus.rpt = 1'b0;
        if (bus.out_en) seen_oe = 1'b1;
        if (!bus.syn) s_low++;
        if (bus.out_en && bus.syn) ln++;
        if (seen_oe && !bus.out_en) oe_n++;
        if (seen_oe && !bus.out_en && !bus.done) break;
      end
    end
    bus.trig = 1'b0;
    check("rpt_done_pulses", dn, 3);
    check("rpt_syn_low", s_low, 21);
    check("rpt_syn_high_oe", ln, 4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
